// File: rtl/tone_synth_pkg.sv
// Shared constants and types for the multi-tone synthesizer.
package tone_synth_pkg;

  typedef enum logic [1:0] {
    FLD_FREQ  = 2'd0,
    FLD_PHASE = 2'd1,
    FLD_MAG   = 2'd2,
    FLD_RSVD  = 2'd3
  } cfg_field_e;

  localparam int LUT_AMPL   = 32767;
  localparam int LUT_WIDTH  = 16;
  localparam int PROD_SHIFT = 15;

endpackage

// File: rtl/tone_synth_if.sv
// Configuration port and sample stream of tone_synth.
interface tone_synth_if
  import tone_synth_pkg::*;
#(
  parameter int SINK_WIDTH = 14,
  parameter int TONES      = 4
) ();

  logic                         sample_en;
  logic                         cfg_we;
  logic [$clog2(TONES)-1:0]     cfg_tone;
  cfg_field_e                   cfg_field;
  logic [31:0]                  cfg_data;
  logic                         cfg_commit;
  logic                         cfg_phase_clr;
  logic                         cfg_busy;
  logic signed [SINK_WIDTH-1:0] source;
  logic                         source_valid;

  modport master (
    output sample_en, cfg_we, cfg_tone, cfg_field, cfg_data, cfg_commit, cfg_phase_clr,
    input  cfg_busy, source, source_valid
  );

  modport slave (
    input  sample_en, cfg_we, cfg_tone, cfg_field, cfg_data, cfg_commit, cfg_phase_clr,
    output cfg_busy, source, source_valid
  );

endinterface

// File: rtl/sine_lut.sv
// Full-cycle sine ROM with a single registered read port.
module sine_lut
  import tone_synth_pkg::*;
#(
  parameter int LUT_DEPTH = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [LUT_DEPTH-1:0]        addr,
  output logic signed [LUT_WIDTH-1:0] data
);

  localparam int ENTRIES = 2 ** LUT_DEPTH;

  function automatic logic signed [LUT_WIDTH-1:0] sine_entry(input int idx);
    real angle;
    int  val;
    angle = 2.0 * 3.14159265358979323846 * real'(idx) / real'(ENTRIES);
    val   = int'(real'(LUT_AMPL) * $sin(angle));
    return LUT_WIDTH'(val);
  endfunction

  logic signed [LUT_WIDTH-1:0] rom [ENTRIES];
  logic signed [LUT_WIDTH-1:0] data_q, data_d;

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_rom
    localparam logic signed [LUT_WIDTH-1:0] VAL = sine_entry(gi);
    assign rom[gi] = VAL;
  end

  always_comb data_d = rom[addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/tone_synth.sv
// Multi-tone DDS: per-tone phase accumulators and sine lookup, scaled,
// summed and saturated into a signed sample stream.
module tone_synth
  import tone_synth_pkg::*;
#(
  parameter int SINK_WIDTH  = 14,
  parameter int TONES       = 4,
  parameter int PHASE_WIDTH = 32,
  parameter int LUT_DEPTH   = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  tone_synth_if.slave bus
);

  localparam int TW    = $clog2(TONES);
  localparam int PRODW = 17;
  localparam int PFW   = 2 * LUT_WIDTH + 1;
  localparam int SUMW  = PRODW + $clog2(TONES);
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;
  localparam logic signed [SUMW-1:0] SAT_HI = SUMW'(2 ** (SINK_WIDTH - 1) - 1);
  localparam logic signed [SUMW-1:0] SAT_LO = SUMW'(-(2 ** (SINK_WIDTH - 1)));

  logic [0:0] state_q, state_d;
  logic       clr_q, clr_d;
  logic       apply, clr_apply;
  logic       v0_q, v0_d, v1_q, v1_d, v2_q, v2_d, valid_q, valid_d;
  logic signed [SINK_WIDTH-1:0] source_q, source_d;
  logic signed [SUMW-1:0]       sum;
  logic signed [PRODW-1:0]      prod_w [TONES];

  // A commit landing in the apply cycle is folded into that apply, clr included.
  always_comb begin
    apply     = bus.sample_en && (state_q == ST_PENDING);
    clr_apply = clr_q || (bus.cfg_commit && bus.cfg_phase_clr);
    state_d   = state_q;
    clr_d     = clr_q;
    if (apply) begin
      state_d = ST_IDLE;
      clr_d   = 1'b0;
    end else if (bus.cfg_commit) begin
      state_d = ST_PENDING;
      clr_d   = clr_q || bus.cfg_phase_clr;
    end
  end

  for (genvar gi = 0; gi < TONES; gi++) begin : g_tone
    localparam logic [TW-1:0] IDX = TW'(gi);

    logic [PHASE_WIDTH-1:0] freq_sh_q, freq_sh_d, off_sh_q, off_sh_d;
    logic [PHASE_WIDTH-1:0] freq_q, freq_d, off_q, off_d, acc_q, acc_d;
    logic [15:0]            mag_sh_q, mag_sh_d, mag_q, mag_d;
    logic [15:0]            mag0_q, mag0_d, mag1_q, mag1_d;
    logic [LUT_DEPTH-1:0]   addr_q, addr_d;
    logic signed [LUT_WIDTH-1:0] lut_data;
    logic signed [PRODW-1:0]     prod_q, prod_d;
    logic                        wr_en;

    always_comb begin
      wr_en     = bus.cfg_we && !apply && (bus.cfg_tone == IDX);
      freq_sh_d = freq_sh_q;
      off_sh_d  = off_sh_q;
      mag_sh_d  = mag_sh_q;
      if (wr_en) begin
        case (bus.cfg_field)
          FLD_FREQ:  freq_sh_d = PHASE_WIDTH'(bus.cfg_data);
          FLD_PHASE: off_sh_d  = PHASE_WIDTH'(bus.cfg_data);
          FLD_MAG:   mag_sh_d  = bus.cfg_data[15:0];
          default:   ;
        endcase
      end
      freq_d = apply ? freq_sh_q : freq_q;
      off_d  = apply ? off_sh_q  : off_q;
      mag_d  = apply ? mag_sh_q  : mag_q;
      acc_d  = acc_q;
      if (apply && clr_apply) acc_d = '0;
      else if (bus.sample_en) acc_d = acc_q + freq_q;
      // Magnitude travels with the sample so an apply never splits one.
      addr_d = LUT_DEPTH'((acc_q + off_q) >> (PHASE_WIDTH - LUT_DEPTH));
      mag0_d = mag_q;
      mag1_d = mag0_q;
      prod_d = PRODW'((PFW'(lut_data) * PFW'($signed({1'b0, mag1_q}))) >>> PROD_SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        freq_sh_q <= '0;
        off_sh_q  <= '0;
        mag_sh_q  <= '0;
        freq_q    <= '0;
        off_q     <= '0;
        mag_q     <= '0;
        acc_q     <= '0;
        addr_q    <= '0;
        mag0_q    <= '0;
        mag1_q    <= '0;
        prod_q    <= '0;
      end else begin
        freq_sh_q <= freq_sh_d;
        off_sh_q  <= off_sh_d;
        mag_sh_q  <= mag_sh_d;
        freq_q    <= freq_d;
        off_q     <= off_d;
        mag_q     <= mag_d;
        acc_q     <= acc_d;
        addr_q    <= addr_d;
        mag0_q    <= mag0_d;
        mag1_q    <= mag1_d;
        prod_q    <= prod_d;
      end
    end

    sine_lut #(.LUT_DEPTH(LUT_DEPTH)) u_lut (
      .clk  (clk),
      .rst_n(rst_n),
      .addr (addr_q),
      .data (lut_data)
    );

    assign prod_w[gi] = prod_q;
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < TONES; k++) sum = sum + SUMW'(prod_w[k]);
    v0_d     = bus.sample_en;
    v1_d     = v0_q;
    v2_d     = v1_q;
    valid_d  = v2_q;
    source_d = source_q;
    if (v2_q) begin
      if (sum > SAT_HI)      source_d = SAT_HI[SINK_WIDTH-1:0];
      else if (sum < SAT_LO) source_d = SAT_LO[SINK_WIDTH-1:0];
      else                   source_d = sum[SINK_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      clr_q    <= 1'b0;
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      valid_q  <= 1'b0;
      source_q <= '0;
    end else begin
      state_q  <= state_d;
      clr_q    <= clr_d;
      v0_q     <= v0_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      valid_q  <= valid_d;
      source_q <= source_d;
    end
  end

  assign bus.cfg_busy     = (state_q == ST_PENDING);
  assign bus.source       = source_q;
  assign bus.source_valid = valid_q;

endmodule

// File: tb/tb_tone_synth.sv
// Directed bench for tone_synth: reset, DC, frequency, saturation,
// latency/throughput and commit corner cases against hand-computed samples.
module tb_tone_synth;
  import tone_synth_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   got_q [$];
  int   exp_q [$];
  int   nval, first_t, last_t;

  tone_synth_if #(.SINK_WIDTH(14), .TONES(4)) bus ();

  tone_synth #(
    .SINK_WIDTH (14),
    .TONES      (4),
    .PHASE_WIDTH(32),
    .LUT_DEPTH  (10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #10 clk = ~clk;

  always @(negedge clk)
    if (rst_n && bus.source_valid) got_q.push_back(int'(bus.source));

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.sample_en     = 1'b0;
    bus.cfg_we        = 1'b0;
    bus.cfg_tone      = '0;
    bus.cfg_field     = FLD_FREQ;
    bus.cfg_data      = '0;
    bus.cfg_commit    = 1'b0;
    bus.cfg_phase_clr = 1'b0;
  endtask

  task automatic wr(input int t, input cfg_field_e f, input logic [31:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_tone  = 2'(t);
    bus.cfg_field = f;
    bus.cfg_data  = d;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic commit(input logic clr);
    bus.cfg_commit    = 1'b1;
    bus.cfg_phase_clr = clr;
    tick();
    bus.cfg_commit    = 1'b0;
    bus.cfg_phase_clr = 1'b0;
  endtask

  task automatic strobe(input int n);
    bus.sample_en = 1'b1;
    repeat (n) tick();
    bus.sample_en = 1'b0;
  endtask

  task automatic drain();
    repeat (6) tick();
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    foreach (exp_q[i])
      check($sformatf("%s[%0d]", tag, i), (i < got_q.size()) ? got_q[i] : 32'sh7fff_ffff, exp_q[i]);
    got_q.delete();
  endtask

  initial begin
    idle();
    for (int i = 0; i < 6; i++) begin
      bus.sample_en     = 1'($urandom);
      bus.cfg_we        = 1'($urandom);
      bus.cfg_tone      = 2'($urandom_range(0, 3));
      bus.cfg_field     = cfg_field_e'($urandom_range(0, 3));
      bus.cfg_data      = $urandom;
      bus.cfg_commit    = 1'($urandom);
      bus.cfg_phase_clr = 1'($urandom);
      tick();
    end
    check("rst_source", bus.source, 0);
    check("rst_valid", bus.source_valid, 0);
    check("rst_busy", bus.cfg_busy, 0);
    idle();
    rst_n = 1'b1;
    got_q.delete();
    strobe(3);
    drain();
    exp_q = '{0, 0, 0};
    check_stream("post_rst");

    // Single tone DC: first sample still uses the reset configuration.
    wr(0, FLD_MAG, 32'd1024);
    wr(0, FLD_PHASE, 32'h4000_0000);
    wr(0, FLD_FREQ, 32'd0);
    commit(1'b0);
    check("dc_busy_set", bus.cfg_busy, 1);
    strobe(1);
    check("dc_busy_clr", bus.cfg_busy, 0);
    strobe(3);
    drain();
    exp_q = '{0, 1023, 1023, 1023};
    check_stream("dc");

    // Quarter-cycle steps from a cleared accumulator.
    wr(0, FLD_FREQ, 32'h4000_0000);
    wr(0, FLD_PHASE, 32'd0);
    commit(1'b1);
    strobe(7);
    drain();
    exp_q = '{1023, 0, 1023, 0, -1024, 0, 1023};
    check_stream("freq");

    for (int t = 0; t < 4; t++) begin
      wr(t, FLD_MAG, 32'd8191);
      wr(t, FLD_FREQ, 32'd0);
      wr(t, FLD_PHASE, 32'h4000_0000);
    end
    commit(1'b1);
    strobe(3);
    drain();
    exp_q = '{0, 8191, 8191};
    check_stream("sat_pos");

    for (int t = 0; t < 4; t++) wr(t, FLD_PHASE, 32'hC000_0000);
    commit(1'b0);
    strobe(3);
    drain();
    exp_q = '{8191, -8192, -8192};
    check_stream("sat_neg");

    got_q.delete();
    bus.sample_en = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      bus.sample_en = 1'b0;
      check($sformatf("lat_valid_e%0d", t), bus.source_valid, (t == 4) ? 1 : 0);
      if (t == 4) check("lat_source", bus.source, -8192);
    end
    got_q.delete();

    nval    = 0;
    first_t = -1;
    last_t  = -1;
    bus.sample_en = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (t == 10) bus.sample_en = 1'b0;
      if (bus.source_valid) begin
        nval++;
        if (first_t < 0) first_t = t;
        last_t = t;
      end
    end
    check("b2b_count", nval, 10);
    check("b2b_first", first_t, 4);
    check("b2b_last", last_t, 13);
    got_q.delete();

    for (int t = 1; t < 4; t++) wr(t, FLD_MAG, 32'd0);
    wr(0, FLD_MAG, 32'd1024);
    wr(0, FLD_FREQ, 32'h4000_0000);
    wr(0, FLD_PHASE, 32'd0);
    commit(1'b1);
    strobe(2);
    drain();
    exp_q = '{-8192, 0};
    check_stream("cc_setup");

    // Second commit is absorbed but contributes its phase clear.
    commit(1'b0);
    commit(1'b1);
    check("cc_busy_held", bus.cfg_busy, 1);
    strobe(1);
    check("cc_busy_clr", bus.cfg_busy, 0);
    strobe(2);
    drain();
    exp_q = '{1023, 0, 1023};
    check_stream("cc_double");

    commit(1'b1);
    bus.cfg_we    = 1'b1;
    bus.cfg_tone  = 2'd0;
    bus.cfg_field = FLD_MAG;
    bus.cfg_data  = 32'd2048;
    bus.sample_en = 1'b1;
    tick();
    bus.cfg_we = 1'b0;
    strobe(4);
    drain();
    check("apw_busy", bus.cfg_busy, 0);
    exp_q = '{0, 0, 1023, 0, -1024};
    check_stream("apply_write");

    got_q.delete();
    strobe(2);
    rst_n = 1'b0;
    tick();
    check("mid_rst_source", bus.source, 0);
    check("mid_rst_valid", bus.source_valid, 0);
    rst_n = 1'b1;
    repeat (8) tick();
    check("mid_rst_no_pulse", got_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
